// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller states and the
// bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index WIDTH steps; never narrower than one bit.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells: a half adder and a full adder composed of two
// half adders with their carries ORed together.
module half_adder (
    input  logic left,
    input  logic right,
    output logic sum,
    output logic carry
);
    assign sum   = left ^ right;
    assign carry = left & right;
endmodule

module full_adder (
    input  logic left,
    input  logic right,
    input  logic carry_in,
    output logic sum,
    output logic carry
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .left  (left),
        .right (right),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .left  (s0),
        .right (carry_in),
        .sum   (sum),
        .carry (c1)
    );

    assign carry = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shifted LSB-first through one full
// adder with a registered carry. Optional macro SERIAL_ADDER_OVERFLOW_EN adds
// a registered two's-complement overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_shift;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .left     (a_sh_q[0]),
        .right    (b_sh_q[0]),
        .carry_in (carry_q),
        .sum      (fa_s),
        .carry    (fa_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands in bit 0.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift = fa_s;
        end else begin : g_shift_wn
            assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic overflow_q, overflow_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        overflow_d = overflow_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = left;
                    b_sh_d  = right;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = sum_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    // carry_q here is the carry into the MSB, fa_c the carry out of it.
                    overflow_d = carry_q ^ fa_c;
`endif
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder (WIDTH=8 and WIDTH=1
// instances) checked against plain integer addition.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] left;
    logic [7:0] right;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] left1;
    logic [0:0] right1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       carry1;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       overflow;
    logic       overflow1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left      (left),
        .right     (right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .left      (left1),
        .right     (right1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry     (carry1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow1)
`endif
    );

    // One full transaction on the 8-bit instance; hold = cycles of back-pressure in DONE.
    task automatic do_txn(input logic [7:0] l, input logic [7:0] r, input int hold);
        logic [8:0] exp;
        logic       exp_ovf;
        int         k;
        bit         got;
        exp     = {1'b0, l} + {1'b0, r};
        exp_ovf = (l[7] == r[7]) && (exp[7] != l[7]);
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_in_ready got %b want 1", in_ready);
        end
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        left      = l;
        right     = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        left     = 8'($urandom);
        right    = 8'($urandom);
        got = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || k != 8) begin
            errors++;
            $display("FAIL latency %h+%h got %0d cycles (seen=%0b) want 8", l, r, k, got);
        end
        if (!got) return;
        $display("txn %h + %h -> sum %h carry %b (expect %h %b) hold %0d", l, r, sum, carry, exp[7:0], exp[8], hold);
        checks++;
        if (sum !== exp[7:0]) begin
            errors++;
            $display("FAIL sum %h+%h got %h want %h", l, r, sum, exp[7:0]);
        end
        checks++;
        if (carry !== exp[8]) begin
            errors++;
            $display("FAIL carry %h+%h got %b want %b", l, r, carry, exp[8]);
        end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL overflow %h+%h got %b want %b", l, r, overflow, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("overflow model undefined");
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            left     = 8'($urandom);
            right    = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || sum !== exp[7:0] || carry !== exp[8] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d got valid=%b sum=%h carry=%b ready=%b want 1 %h %b 0",
                         h, out_valid, sum, carry, in_ready, exp[7:0], exp[8]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset got ready=%b valid=%b sum=%h carry=%b want 1 0 00 0",
                     in_ready, out_valid, sum, carry);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_txn(8'h00, 8'h00, 0);
        do_txn(8'hFF, 8'h01, 0);
        do_txn(8'h00, 8'h00, 0);
        do_txn(8'h5A, 8'h33, 5);
        do_txn(8'h7F, 8'h01, 0);
        do_txn(8'hFF, 8'hFF, 0);
    endtask

    task automatic test_mid_reset;
        bit seen;
        in_valid = 1'b1;
        left     = 8'hAA;
        right    = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got ready=%b valid=%b sum=%h carry=%b want 1 0 00 0",
                     in_ready, out_valid, sum, carry);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_no_valid got out_valid=1 want 0");
        end
        do_txn(8'h01, 8'h02, 0);
    endtask

    task automatic test_width1;
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            left1      = 1'(i >> 1);
            right1     = 1'(i);
            exp        = {1'b0, left1} + {1'b0, right1};
            out_ready1 = 1'b1;
            in_valid1  = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            @(posedge clk); #1;
            $display("txn w1 %b + %b -> valid %b sum %b carry %b", left1, right1, out_valid1, sum1, carry1);
            checks++;
            if (out_valid1 !== 1'b1 || sum1 !== exp[0] || carry1 !== exp[1]) begin
                errors++;
                $display("FAIL width1 %b+%b got valid=%b sum=%b carry=%b want 1 %b %b",
                         left1, right1, out_valid1, sum1, carry1, exp[0], exp[1]);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
                errors++;
                $display("FAIL width1_release got valid=%b ready=%b want 0 1", out_valid1, in_ready1);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1000; i++) begin
            do_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        in_valid   = 1'b0;
        left       = 8'h00;
        right      = 8'h00;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        left1      = 1'b0;
        right1     = 1'b0;
        out_ready1 = 1'b1;
        test_reset();
        test_directed();
        test_mid_reset();
        test_width1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
